// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch/decode boundary: instruction codes,
// status codes, the D-register layout and its nop bubble value.
package y86_pkg;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ERR = 2'd2;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {
        FL_RUN,
        FL_LOCKED
    } lock_state_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pc;
        logic [1:0]  status;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        icode:  I_NOP,
        ifun:   4'h0,
        ra:     REG_NONE,
        rb:     REG_NONE,
        valc:   64'd0,
        valp:   64'd0,
        pc:     64'd0,
        status: S_AOK
    };

    // A jXX reaching M with its condition false was predicted taken wrongly.
    function automatic logic is_mispredict(input logic [3:0] icode, input logic cnd);
        return (icode == I_JXX) && !cnd;
    endfunction

endpackage

// File: rtl/fetch_decode_reg_pc_predict_select.sv
// Combinational PC select feeding fetch, plus next-PC prediction from the
// instruction currently being fetched.
module pc_predict_select
    import y86_pkg::*;
(
    input  logic [3:0]  i_m_icode,
    input  logic        i_m_cnd,
    input  logic [63:0] i_m_vala,
    input  logic [3:0]  i_w_icode,
    input  logic [63:0] i_w_valm,
    input  logic [63:0] i_f_predpc,
    input  logic [3:0]  i_f_icode,
    input  logic [63:0] i_f_valc,
    input  logic [63:0] i_f_valp,
    output logic [63:0] o_f_pc,
    output logic [63:0] o_pred_pc
);

    always_comb begin
        o_f_pc = i_f_predpc;
        if (is_mispredict(i_m_icode, i_m_cnd)) begin
            o_f_pc = i_m_vala;
        end else if (i_w_icode == I_RET) begin
            o_f_pc = i_w_valm;
        end
    end

    // Jumps and calls are predicted taken; everything else falls through.
    always_comb begin
        o_pred_pc = i_f_valp;
        if ((i_f_icode == I_JXX) || (i_f_icode == I_CALL)) begin
            o_pred_pc = i_f_valc;
        end
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// F register, F/D pipeline register and fetch-lock FSM around Y86-64 fetch.
// Optional FD_PERF_CNT_EN adds saturating D stall/bubble counters.
module fetch_decode_reg
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic [3:0]       M_icode,
    input  logic             M_cnd,
    input  logic [63:0]      M_valA,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [3:0]       f_ra,
    input  logic [3:0]       f_rb,
    input  logic [63:0]      f_valc,
    input  logic [63:0]      f_valp,
    input  logic [1:0]       f_status,
    output logic [63:0]      f_pc,
    output logic [63:0]      F_predPC,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_ra,
    output logic [3:0]       D_rb,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,
    output logic [63:0]      D_pc,
    output logic [1:0]       D_status,
`ifdef FD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
`endif
    output logic             fetch_locked
);

    logic [63:0] r_pred_pc;
    d_reg_t      r_d;
    lock_state_t r_state;
    lock_state_t w_state_next;
    logic [63:0] w_pred_pc;
    logic        w_mispredict;
    logic        w_locked;
    logic        w_d_load;

    pc_predict_select u_pc_predict_select (
        .i_m_icode  (M_icode),
        .i_m_cnd    (M_cnd),
        .i_m_vala   (M_valA),
        .i_w_icode  (W_icode),
        .i_w_valm   (W_valM),
        .i_f_predpc (r_pred_pc),
        .i_f_icode  (f_icode),
        .i_f_valc   (f_valc),
        .i_f_valp   (f_valp),
        .o_f_pc     (f_pc),
        .o_pred_pc  (w_pred_pc)
    );

    assign w_mispredict = is_mispredict(M_icode, M_cnd);
    assign w_locked     = (r_state == FL_LOCKED);
    assign w_d_load     = !D_stall && !D_bubble && !w_locked;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FL_RUN:    if (w_d_load && (f_status != S_AOK)) w_state_next = FL_LOCKED;
            FL_LOCKED: if (w_mispredict) w_state_next = FL_RUN;
            default:   w_state_next = FL_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FL_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // While locked, only the recovering mispredict may move F, and it bypasses F_stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pred_pc <= RESET_PC;
        end else if (w_locked) begin
            if (w_mispredict) r_pred_pc <= M_valA;
        end else if (!F_stall) begin
            r_pred_pc <= w_pred_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_d <= D_BUBBLE;
        end else if (D_stall) begin
            r_d <= r_d;
        end else if (D_bubble || w_locked) begin
            r_d <= D_BUBBLE;
        end else begin
            r_d <= '{icode: f_icode, ifun: f_ifun, ra: f_ra, rb: f_rb,
                     valc: f_valc, valp: f_valp, pc: f_pc, status: f_status};
        end
    end

`ifdef FD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_bubble_ins;

    assign w_bubble_ins = !D_stall && (D_bubble || w_locked);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (D_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble_ins && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W == 0);
`endif

    assign F_predPC     = r_pred_pc;
    assign D_icode      = r_d.icode;
    assign D_ifun       = r_d.ifun;
    assign D_ra         = r_d.ra;
    assign D_rb         = r_d.rb;
    assign D_valC       = r_d.valc;
    assign D_valP       = r_d.valp;
    assign D_pc         = r_d.pc;
    assign D_status     = r_d.status;
    assign fetch_locked = w_locked;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Scoreboard bench for fetch_decode_reg; define FD_PERF_CNT_EN to also
// exercise the stall/bubble counters (instantiated with CNT_W=4).
module tb_fetch_decode_reg;

    logic        clock, reset;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_cnd;
    logic [63:0] M_valA, W_valM;
    logic [3:0]  f_icode, f_ifun, f_ra, f_rb;
    logic [63:0] f_valc, f_valp;
    logic [1:0]  f_status;
    logic [63:0] f_pc, F_predPC, D_valC, D_valP, D_pc;
    logic [3:0]  D_icode, D_ifun, D_ra, D_rb;
    logic [1:0]  D_status;
    logic        fetch_locked;
`ifdef FD_PERF_CNT_EN
    logic [3:0]  stall_cnt, bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [63:0] predpc;
        logic [3:0]  dicode;
        logic [3:0]  dra;
        logic [63:0] dpc;
        logic        locked;
    } exp_t;

    typedef struct {
        logic        fst, dst, dbub;
        logic [3:0]  micode;
        logic        mcnd;
        logic [63:0] mvala;
        logic [3:0]  wicode;
        logic [63:0] wvalm;
        logic [3:0]  ficode, fra;
        logic [63:0] fvalc, fvalp;
        logic [1:0]  fstat;
        logic [63:0] xfpc;
        exp_t        x;
    } step_t;

    exp_t exp_q[$];

`ifdef FD_PERF_CNT_EN
    fetch_decode_reg #(.RESET_PC(64'd0), .CNT_W(4)) dut (
`else
    fetch_decode_reg #(.RESET_PC(64'd0)) dut (
`endif
        .clock(clock), .reset(reset),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_ra(f_ra), .f_rb(f_rb),
        .f_valc(f_valc), .f_valp(f_valp), .f_status(f_status),
        .f_pc(f_pc), .F_predPC(F_predPC),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_ra(D_ra), .D_rb(D_rb),
        .D_valC(D_valC), .D_valP(D_valP), .D_pc(D_pc), .D_status(D_status),
`ifdef FD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .fetch_locked(fetch_locked)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    function automatic step_t mk(
        input logic fst, input logic dst, input logic dbub,
        input logic [3:0] micode, input logic mcnd, input logic [63:0] mvala,
        input logic [3:0] wicode, input logic [63:0] wvalm,
        input logic [3:0] ficode, input logic [3:0] fra,
        input logic [63:0] fvalc, input logic [63:0] fvalp, input logic [1:0] fstat,
        input logic [63:0] xfpc, input logic [63:0] xpred, input logic [3:0] xicode,
        input logic [3:0] xra, input logic [63:0] xpc, input logic xlock);
        step_t s;
        s.fst = fst; s.dst = dst; s.dbub = dbub;
        s.micode = micode; s.mcnd = mcnd; s.mvala = mvala;
        s.wicode = wicode; s.wvalm = wvalm;
        s.ficode = ficode; s.fra = fra; s.fvalc = fvalc; s.fvalp = fvalp; s.fstat = fstat;
        s.xfpc = xfpc;
        s.x = '{predpc: xpred, dicode: xicode, dra: xra, dpc: xpc, locked: xlock};
        return s;
    endfunction

    task automatic apply(input step_t s);
        F_stall = s.fst; D_stall = s.dst; D_bubble = s.dbub;
        M_icode = s.micode; M_cnd = s.mcnd; M_valA = s.mvala;
        W_icode = s.wicode; W_valM = s.wvalm;
        f_icode = s.ficode; f_ra = s.fra; f_valc = s.fvalc; f_valp = s.fvalp;
        f_status = s.fstat;
    endtask

    task automatic idle_inputs();
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 4'h0; M_cnd = 1'b1; M_valA = '0;
        W_icode = 4'h0; W_valM = '0;
        f_icode = 4'h1; f_ifun = 4'h0; f_ra = 4'hF; f_rb = 4'hF;
        f_valc = '0; f_valp = '0; f_status = 2'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #5 reset = 1'b1;
        #1;
        n_checks++;
        if (F_predPC !== 64'd0 || D_icode !== 4'h1 || D_ra !== 4'hF || D_status !== 2'd0 || fetch_locked !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: F_predPC=%h D_icode=%h D_ra=%h D_status=%h locked=%b, required 0 1 f 0 0",
                     F_predPC, D_icode, D_ra, D_status, fetch_locked);
        end
        @(posedge clock); #1;
        n_checks++;
        if (F_predPC !== 64'd0 || D_icode !== 4'h1 || D_pc !== 64'd0 || fetch_locked !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_held: F_predPC=%h D_icode=%h D_pc=%h locked=%b, required 0 1 0 0",
                     F_predPC, D_icode, D_pc, fetch_locked);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        step_t s[$];
        exp_t  e, obs;
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h1,4'hF,64'h0,64'h1,2'd0,
                       64'h0, 64'h1, 4'h1, 4'hF, 64'h0, 0));
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h3,4'hF,64'h123,64'hB,2'd0,
                       64'h1, 64'hB, 4'h3, 4'hF, 64'h1, 0));
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(s[k].x);
            #1;
            n_checks++;
            if (f_pc !== s[k].xfpc) begin
                n_errors++;
                $display("FAIL fetch f_pc step %0d: got %h required %h", k, f_pc, s[k].xfpc);
            end
            @(posedge clock); #1;
            e = exp_q.pop_front();
            obs = '{predpc: F_predPC, dicode: D_icode, dra: D_ra, dpc: D_pc, locked: fetch_locked};
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL fetch regs step %0d: got pred=%h icode=%h ra=%h pc=%h lk=%b required pred=%h icode=%h ra=%h pc=%h lk=%b",
                         k, obs.predpc, obs.dicode, obs.dra, obs.dpc, obs.locked, e.predpc, e.dicode, e.dra, e.dpc, e.locked);
            end
        end
    endtask

    task automatic test_mispredict();
        step_t s[$];
        exp_t  e, obs;
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h7,4'hF,64'h40,64'h14,2'd0,
                       64'hB, 64'h40, 4'h7, 4'hF, 64'hB, 0));
        s.push_back(mk(0,0,0, 4'h7,0,64'h20, 4'h0,64'h0, 4'h6,4'h2,64'h0,64'h22,2'd0,
                       64'h20, 64'h22, 4'h6, 4'h2, 64'h20, 0));
        s.push_back(mk(0,0,0, 4'h7,1,64'h20, 4'h0,64'h0, 4'h8,4'hF,64'h300,64'h2B,2'd0,
                       64'h22, 64'h300, 4'h8, 4'hF, 64'h22, 0));
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(s[k].x);
            #1;
            n_checks++;
            if (f_pc !== s[k].xfpc) begin
                n_errors++;
                $display("FAIL mispredict f_pc step %0d: got %h required %h", k, f_pc, s[k].xfpc);
            end
            @(posedge clock); #1;
            e = exp_q.pop_front();
            obs = '{predpc: F_predPC, dicode: D_icode, dra: D_ra, dpc: D_pc, locked: fetch_locked};
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL mispredict regs step %0d: got pred=%h icode=%h ra=%h pc=%h lk=%b required pred=%h icode=%h ra=%h pc=%h lk=%b",
                         k, obs.predpc, obs.dicode, obs.dra, obs.dpc, obs.locked, e.predpc, e.dicode, e.dra, e.dpc, e.locked);
            end
        end
    endtask

    task automatic test_ret();
        step_t s[$];
        exp_t  e, obs;
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h9,64'h88, 4'h1,4'hF,64'h0,64'h89,2'd0,
                       64'h88, 64'h89, 4'h1, 4'hF, 64'h88, 0));
        s.push_back(mk(0,0,0, 4'h7,0,64'h50, 4'h9,64'h88, 4'h6,4'h3,64'h0,64'h52,2'd0,
                       64'h50, 64'h52, 4'h6, 4'h3, 64'h50, 0));
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(s[k].x);
            #1;
            n_checks++;
            if (f_pc !== s[k].xfpc) begin
                n_errors++;
                $display("FAIL ret f_pc step %0d: got %h required %h", k, f_pc, s[k].xfpc);
            end
            @(posedge clock); #1;
            e = exp_q.pop_front();
            obs = '{predpc: F_predPC, dicode: D_icode, dra: D_ra, dpc: D_pc, locked: fetch_locked};
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL ret regs step %0d: got pred=%h icode=%h ra=%h pc=%h lk=%b required pred=%h icode=%h ra=%h pc=%h lk=%b",
                         k, obs.predpc, obs.dicode, obs.dra, obs.dpc, obs.locked, e.predpc, e.dicode, e.dra, e.dpc, e.locked);
            end
        end
    endtask

    task automatic test_stall_bubble();
        step_t s[$];
        exp_t  e, obs;
        s.push_back(mk(0,1,1, 4'h0,1,64'h0, 4'h0,64'h0, 4'h3,4'hF,64'h0,64'h5C,2'd0,
                       64'h52, 64'h5C, 4'h6, 4'h3, 64'h50, 0));
        s.push_back(mk(0,0,1, 4'h0,1,64'h0, 4'h0,64'h0, 4'h6,4'h4,64'h0,64'h5E,2'd0,
                       64'h5C, 64'h5E, 4'h1, 4'hF, 64'h0, 0));
        s.push_back(mk(1,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h6,4'h5,64'h0,64'h60,2'd0,
                       64'h5E, 64'h5E, 4'h6, 4'h5, 64'h5E, 0));
        s.push_back(mk(1,1,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h3,4'hF,64'h0,64'h68,2'd0,
                       64'h5E, 64'h5E, 4'h6, 4'h5, 64'h5E, 0));
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(s[k].x);
            #1;
            n_checks++;
            if (f_pc !== s[k].xfpc) begin
                n_errors++;
                $display("FAIL stall_bubble f_pc step %0d: got %h required %h", k, f_pc, s[k].xfpc);
            end
            @(posedge clock); #1;
            e = exp_q.pop_front();
            obs = '{predpc: F_predPC, dicode: D_icode, dra: D_ra, dpc: D_pc, locked: fetch_locked};
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL stall_bubble regs step %0d: got pred=%h icode=%h ra=%h pc=%h lk=%b required pred=%h icode=%h ra=%h pc=%h lk=%b",
                         k, obs.predpc, obs.dicode, obs.dra, obs.dpc, obs.locked, e.predpc, e.dicode, e.dra, e.dpc, e.locked);
            end
        end
    endtask

    task automatic test_lock();
        step_t s[$];
        exp_t  e, obs;
        // Error status under D_stall never reaches D, so no lock.
        s.push_back(mk(0,1,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h6,4'h1,64'h0,64'h60,2'd2,
                       64'h5E, 64'h60, 4'h6, 4'h5, 64'h5E, 0));
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h0,4'hF,64'h0,64'h61,2'd1,
                       64'h60, 64'h61, 4'h0, 4'hF, 64'h60, 1));
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h6,4'h2,64'h0,64'h70,2'd0,
                       64'h61, 64'h61, 4'h1, 4'hF, 64'h0, 1));
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h6,4'h2,64'h0,64'h70,2'd0,
                       64'h61, 64'h61, 4'h1, 4'hF, 64'h0, 1));
        s.push_back(mk(1,0,0, 4'h7,0,64'h30, 4'h0,64'h0, 4'h6,4'h2,64'h0,64'h70,2'd0,
                       64'h30, 64'h30, 4'h1, 4'hF, 64'h0, 0));
        s.push_back(mk(0,0,0, 4'h0,1,64'h0, 4'h0,64'h0, 4'h6,4'h7,64'h0,64'h32,2'd0,
                       64'h30, 64'h32, 4'h6, 4'h7, 64'h30, 0));
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(s[k].x);
            #1;
            n_checks++;
            if (f_pc !== s[k].xfpc) begin
                n_errors++;
                $display("FAIL lock f_pc step %0d: got %h required %h", k, f_pc, s[k].xfpc);
            end
            @(posedge clock); #1;
            e = exp_q.pop_front();
            obs = '{predpc: F_predPC, dicode: D_icode, dra: D_ra, dpc: D_pc, locked: fetch_locked};
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL lock regs step %0d: got pred=%h icode=%h ra=%h pc=%h lk=%b required pred=%h icode=%h ra=%h pc=%h lk=%b",
                         k, obs.predpc, obs.dicode, obs.dra, obs.dpc, obs.locked, e.predpc, e.dicode, e.dra, e.dpc, e.locked);
            end
        end
    endtask

`ifdef FD_PERF_CNT_EN
    task automatic test_perf();
        idle_inputs();
        #4 reset = 1'b1;
        #1;
        n_checks++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_errors++;
            $display("FAIL perf_reset: stall_cnt=%0d bubble_cnt=%0d, required 0 0", stall_cnt, bubble_cnt);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        D_stall = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        D_stall = 1'b0; D_bubble = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        D_bubble = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (stall_cnt !== 4'd3 || bubble_cnt !== 4'd2) begin
            n_errors++;
            $display("FAIL perf_count: stall_cnt=%0d bubble_cnt=%0d, required 3 2", stall_cnt, bubble_cnt);
        end
        D_stall = 1'b1;
        repeat (20) begin @(posedge clock); #1; end
        D_stall = 1'b0;
        n_checks++;
        if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd2) begin
            n_errors++;
            $display("FAIL perf_saturate: stall_cnt=%0d bubble_cnt=%0d, required 15 2", stall_cnt, bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_mispredict();
        test_ret();
        test_stall_bubble();
        test_lock();
`ifdef FD_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
